glitch_filter_scheduler: RTL and testbench

//  Time-multiplexes one glitch-eliminator datapath across N_CH raw inputs.
//  A level change on a channel is accepted only after THRESH consecutive samples agree.
//  Per-channel filtered level and run counter live in register arrays. A round-robin

---
 rtl/glitch_filt_pkg.sv | 22 ++
 rtl/sample_prescaler.sv | 32 +++
 rtl/glitch_filter_scheduler.sv | 152 +++++++++++++++
 tb/tb_glitch_filter_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_filt_pkg.sv
// Purpose: shared types and constants for the time-multiplexed glitch filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package glitch_filt_pkg;

   // Scheduler states: 2-bit encoding, IDLE is the reset state
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      EVAL = 2'd2,
      EMIT = 2'd3
   } state_t;

   // Default number of consecutive agreeing samples before a level is accepted
   localparam int THRESH_DEF = 3;

   // Round-robin successor of a channel index, wrapping n-1 -> 0
   function automatic int unsigned next_idx(input int unsigned cur, input int unsigned n);
      return (cur >= n - 1) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/sample_prescaler.sv
// Purpose: divides clk down to a one-cycle sample tick every DIV cycles while enabled.
// Latency: first tick DIV cycles after en rises; counter held at 0 while en is low.
// Backpressure: none; ticks are fire-and-forget, the consumer must latch them.
module sample_prescaler #(
   parameter int DIV = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] count;

   // Free-running divide counter, parked at zero whenever the scheduler is disabled
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + PW'(1);
      end
   end

   // Tick is the terminal count itself, so DIV=1 yields a tick on every enabled cycle
   assign tick = en && (count == LAST);

endmodule

// File: rtl/glitch_filter_scheduler.sv
// Purpose: one shared glitch-eliminator datapath visited round-robin across N_CH inputs.
// Latency: 2 sync cycles + thr visits of the channel (N_CH ticks apart) + 1 to filt.
// Backpressure: evt_ready low holds EMIT and freezes the scheduler; ticks meanwhile set overrun.
module glitch_filter_scheduler
   import glitch_filt_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CH_W  = 2,
   parameter int CNT_W = 4,
   parameter int DIV   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [N_CH-1:0]   din,
   input  logic [CNT_W-1:0]  cfg_thresh,
   output logic [N_CH-1:0]   filt,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CH_W-1:0]   evt_ch,
   output logic              evt_level,
   output logic              overrun
);

   logic [N_CH-1:0]  sync1;
   logic [N_CH-1:0]  sync2;
   logic             tick;
   logic             tick_pend;
   logic             consume;
   state_t           state;
   logic [CH_W-1:0]  ch_sel;
   logic [CH_W-1:0]  ch_next;
   logic [CNT_W-1:0] cnt [N_CH];

   logic             s_cur;
   logic             f_cur;
   logic [CNT_W-1:0] cnt_cur;
   logic [CNT_W:0]   cnt_inc;
   logic [CNT_W-1:0] thr;
   logic [CNT_W:0]   thr_ext;

   sample_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   // Two-flop synchroniser; the datapath only ever looks at sync2
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // The EVAL cycle is the only consumer of a pending tick
   assign consume = (state == EVAL);

   // Latch ticks until EVAL takes them; a tick landing on a still-pending one is lost
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_pend <= 1'b0;
         overrun   <= 1'b0;
      end else if (tick) begin
         // A tick coinciding with EVAL replaces the one being consumed, so it is not a drop
         if (tick_pend && !consume) begin
            overrun <= 1'b1;
         end
         tick_pend <= 1'b1;
      end else if (consume) begin
         tick_pend <= 1'b0;
      end
   end

   // Shared datapath operands for the currently selected channel
   assign s_cur   = sync2[ch_sel];
   assign f_cur   = filt[ch_sel];
   assign cnt_cur = cnt[ch_sel];
   assign cnt_inc = {1'b0, cnt_cur} + (CNT_W+1)'(1);
   assign thr     = (cfg_thresh == '0) ? CNT_W'(1) : cfg_thresh;
   assign thr_ext = {1'b0, thr};
   assign ch_next = CH_W'(next_idx(int'(ch_sel), N_CH));

   // Scheduler FSM: owns the per-channel arrays, the channel pointer and the event register
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ch_sel    <= '0;
         filt      <= '0;
         evt_valid <= 1'b0;
         evt_ch    <= '0;
         evt_level <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (!en) begin
                  state <= IDLE;
               end else if (tick_pend) begin
                  state <= EVAL;
               end
            end
            EVAL: begin
               if (s_cur == f_cur) begin
                  // Sample agrees with the accepted level: any partial run is abandoned
                  cnt[ch_sel] <= '0;
                  ch_sel      <= ch_next;
                  state       <= WAIT;
               end else if (cnt_inc < thr_ext) begin
                  // Still short of the threshold; cnt_inc < thr so the increment cannot wrap
                  cnt[ch_sel] <= cnt_inc[CNT_W-1:0];
                  ch_sel      <= ch_next;
                  state       <= WAIT;
               end else begin
                  // Run long enough: commit the level now, the event reports it afterwards
                  filt[ch_sel] <= s_cur;
                  cnt[ch_sel]  <= '0;
                  evt_ch       <= ch_sel;
                  evt_level    <= s_cur;
                  evt_valid    <= 1'b1;
                  state        <= EMIT;
               end
            end
            EMIT: begin
               // Channel pointer only advances once the consumer has taken the event
               if (evt_ready) begin
                  evt_valid <= 1'b0;
                  ch_sel    <= ch_next;
                  state     <= en ? WAIT : IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_glitch_filter_scheduler.sv
module tb_glitch_filter_scheduler;

   localparam int N_CH  = 4;
   localparam int CH_W  = 2;
   localparam int CNT_W = 4;
   localparam int DIV   = 2;

   logic             clk;
   logic             rst;
   logic             en;
   logic [N_CH-1:0]  din;
   logic [CNT_W-1:0] cfg_thresh;
   logic [N_CH-1:0]  filt;
   logic             evt_valid;
   logic             evt_ready;
   logic [CH_W-1:0]  evt_ch;
   logic             evt_level;
   logic             overrun;

   typedef struct {
      logic [CH_W-1:0] ch;
      logic            lvl;
   } evt_t;

   evt_t exp_q[$];
   evt_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   glitch_filter_scheduler #(
      .N_CH  (N_CH),
      .CH_W  (CH_W),
      .CNT_W (CNT_W),
      .DIV   (DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .din        (din),
      .cfg_thresh (cfg_thresh),
      .filt       (filt),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_ch     (evt_ch),
      .evt_level  (evt_level),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every accepted handshake must match the oldest expected event
   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got ch=%0d level=%0b, required no event", evt_ch, evt_level);
         end else begin
            mon_e = exp_q.pop_front();
            if (evt_ch !== mon_e.ch || evt_level !== mon_e.lvl) begin
               n_fail++;
               $display("FAIL event_order: got ch=%0d level=%0b, required ch=%0d level=%0b",
                        evt_ch, evt_level, mon_e.ch, mon_e.lvl);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_evt(input logic [CH_W-1:0] ch, input logic lvl);
      evt_t e;
      e.ch  = ch;
      e.lvl = lvl;
      exp_q.push_back(e);
   endtask

   // Waits (bounded) for the scoreboard to empty; ok reports whether it did
   task automatic drain(input int budget, output bit ok);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         cyc(1);
         k++;
      end
      ok = (exp_q.size() == 0);
      exp_q.delete();
      cyc(2);
   endtask

   // Waits (bounded) for evt_valid; ok reports whether it rose
   task automatic await_valid(input int budget, output bit ok);
      int k = 0;
      while (evt_valid !== 1'b1 && k < budget) begin
         cyc(1);
         k++;
      end
      ok = (evt_valid === 1'b1);
   endtask

   task automatic reset_dut(input logic [N_CH-1:0] din_val);
      rst = 1'b1;
      din = din_val;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; din = '0; cfg_thresh = 4'd3; evt_ready = 1'b1;
      cyc(2);
      n_checks++;
      if (filt !== 4'b0000) begin n_fail++; $display("FAIL reset_filt: got %b, required 0000", filt); end
      n_checks++;
      if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evt_valid: got %b, required 0", evt_valid); end
      n_checks++;
      if (evt_ch !== 2'd0 || evt_level !== 1'b0) begin
         n_fail++; $display("FAIL reset_evt_fields: got ch=%0d level=%b, required 0/0", evt_ch, evt_level);
      end
      n_checks++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
      rst = 1'b0;
   endtask

   task automatic test_quiet;
      bit seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         cyc(1);
         if (evt_valid === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL quiet_no_event: got evt_valid=1, required never 1"); end
      n_checks++;
      if (filt !== 4'b0000) begin n_fail++; $display("FAIL quiet_filt: got %b, required 0000", filt); end
      n_checks++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL quiet_overrun: got %b, required 0", overrun); end
   endtask

   task automatic test_edge;
      bit ok;
      din[2] = 1'b1;
      push_evt(2'd2, 1'b1);
      drain(200, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL edge_rise_timeout: got no event, required ch=2 level=1"); end
      n_checks++;
      if (filt !== 4'b0100) begin n_fail++; $display("FAIL edge_rise_filt: got %b, required 0100", filt); end
      din[2] = 1'b0;
      push_evt(2'd2, 1'b0);
      drain(200, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL edge_fall_timeout: got no event, required ch=2 level=0"); end
      n_checks++;
      if (filt !== 4'b0000) begin n_fail++; $display("FAIL edge_fall_filt: got %b, required 0000", filt); end
   endtask

   // A 16-cycle pulse spans exactly two visits of ch1 (one visit per 8 cycles at DIV=2)
   task automatic test_glitch;
      cyc(10);
      din[1] = 1'b1;
      cyc(16);
      din[1] = 1'b0;
      cyc(24);
      n_checks++;
      if (filt !== 4'b0000) begin n_fail++; $display("FAIL glitch_filt: got %b, required 0000", filt); end
      n_checks++;
      if (dut.cnt[1] !== 4'd0) begin n_fail++; $display("FAIL glitch_cnt: got %0d, required 0", dut.cnt[1]); end
   endtask

   task automatic test_backpressure;
      bit ok;
      bit stable = 1'b1;
      logic [CH_W-1:0] ch0;
      logic lvl0;
      logic [CH_W-1:0] sel0;
      reset_dut(4'b0000);
      evt_ready = 1'b0;
      din[0] = 1'b1;
      push_evt(2'd0, 1'b1);
      await_valid(200, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL stall_valid_timeout: got evt_valid=0, required 1"); end
      n_checks++;
      if (filt !== 4'b0001) begin n_fail++; $display("FAIL stall_filt_early: got %b, required 0001", filt); end
      ch0 = evt_ch; lvl0 = evt_level; sel0 = dut.ch_sel;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (evt_valid !== 1'b1 || evt_ch !== ch0 || evt_level !== lvl0 || dut.ch_sel !== sel0)
            stable = 1'b0;
      end
      n_checks++;
      if (!stable) begin n_fail++; $display("FAIL stall_stable: got evt_*/ch_sel changing, required held"); end
      n_checks++;
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL stall_overrun: got %b, required 1", overrun); end
      evt_ready = 1'b1;
      drain(10, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL stall_accept: got event not accepted, required accepted"); end
      n_checks++;
      if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got evt_valid=%b, required 0", evt_valid); end
   endtask

   task automatic test_thresh_zero;
      bit ok;
      cfg_thresh = 4'd0;
      reset_dut(4'b0000);
      cyc(4);
      din[3] = 1'b1;
      push_evt(2'd3, 1'b1);
      drain(16, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL thr0_first_visit: got no event within 16 cycles, required one"); end
      rst = 1'b1;
      din = 4'b1111;
      cyc(2);
      push_evt(2'd0, 1'b1);
      push_evt(2'd1, 1'b1);
      push_evt(2'd2, 1'b1);
      push_evt(2'd3, 1'b1);
      rst = 1'b0;
      drain(100, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL thr0_all_timeout: got missing events, required ch0..ch3"); end
      n_checks++;
      if (filt !== 4'b1111) begin n_fail++; $display("FAIL thr0_all_filt: got %b, required 1111", filt); end
   endtask

   task automatic test_reset_in_emit;
      bit ok;
      cfg_thresh = 4'd3;
      reset_dut(4'b0000);
      evt_ready = 1'b0;
      din[1] = 1'b1;
      await_valid(200, ok);
      n_checks++;
      if (!ok || evt_ch !== 2'd1 || evt_level !== 1'b1) begin
         n_fail++; $display("FAIL emit_pending: got valid=%b ch=%0d level=%b, required 1/1/1", evt_valid, evt_ch, evt_level);
      end
      cyc(6);
      rst = 1'b1;
      din = 4'b0000;
      cyc(1);
      n_checks++;
      if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_emit_valid: got %b, required 0", evt_valid); end
      n_checks++;
      if (filt !== 4'b0000) begin n_fail++; $display("FAIL rst_emit_filt: got %b, required 0000", filt); end
      n_checks++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_emit_overrun: got %b, required 0", overrun); end
      n_checks++;
      if (dut.ch_sel !== 2'd0) begin n_fail++; $display("FAIL rst_emit_ch_sel: got %0d, required 0", dut.ch_sel); end
      rst = 1'b0;
      evt_ready = 1'b1;
      cyc(4);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; din = '0; cfg_thresh = 4'd3; evt_ready = 1'b1;
      test_reset();
      test_quiet();
      test_edge();
      test_glitch();
      test_backpressure();
      test_thresh_zero();
      test_reset_in_emit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
